mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register between the data memory stage and register-file writeback.
- Captures the memory-stage result and formats load data: byte/halfword extraction plus sign/zero extension from the 32-bit word returned by data memory.
- Selects the writeback source, suppresses illegal or misaligned writes and keeps a 64-bit retired-instruction counter.
- Registered outputs also drive the forwarding path back to the execute stage.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, width of retire counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage contents
- flush  in  1  insert bubble
- m_valid  in  1  memory stage holds a valid instruction
- m_rd  in  5  destination register
- m_reg_write  in  1  instruction writes rd
- m_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 treated as ALU
- m_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- m_alu_result  in  XLEN  ALU result / memory address
- m_read_data  in  XLEN  word read from data memory
- m_pc_plus4  in  XLEN  return address for JAL/JALR
- wb_valid  out  1  writeback holds a valid instruction
- wb_rd  out  5  destination register
- wb_we  out  1  register-file write enable
- wb_data  out  XLEN  data to write
- wb_misaligned  out  1  load-address-misaligned flag for the held instruction
- retire_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): wb_valid=0, wb_rd=0, wb_we=0, wb_data=0, wb_misaligned=0, retire_count=0. Reset mid-operation discards held contents immediately.
- Update priority at each posedge clk: flush > stall > capture.
  - flush=1: wb_valid=0, wb_we=0, wb_misaligned=0; wb_rd and wb_data hold.
  - stall=1 (flush=0): all outputs hold; retire_count holds.
  - Otherwise: capture next-state values computed from the m_* inputs.
- Latency: one cycle from m_* inputs to wb_* outputs. No combinational path from inputs to outputs.
- Load formatting, combinational before the register, using off = m_alu_result[1:0]:
  - LB/LBU select byte off of m_read_data (byte 0 = bits 7:0).
  - LH/LHU select halfword off[1] (0 → bits 15:0, 1 → bits 31:16).
  - LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - funct3 011/110/111 are treated as LW.
- Misaligned: set when wb_sel=01 and either halfword load with off[0]=1, or word load with off≠00. The next-state misaligned flag is 1 only for a valid instruction; the write is suppressed.
- wb_data next-state by wb_sel: ALU → m_alu_result; load → formatted load; pc+4 → m_pc_plus4.
- wb_we next-state = m_valid & m_reg_write & (m_rd≠0) & ~misaligned. rd=x0 never writes.
- wb_valid next-state = m_valid. A misaligned instruction still counts as valid.
- retire_count increments by 1 on each capture with m_valid=1 and misaligned=0. It wraps from all-ones to 0 and never increments under stall, flush or reset.
- Invalid capture (m_valid=0): wb_valid=0, wb_we=0, wb_misaligned=0; the data fields may update but are don't-care.

Test Plan:
- Reset, then LB from addr 0x0000_0003 with read_data 0x80FF_1234, rd=5 → next cycle wb_data=0xFFFF_FF80, wb_we=1, wb_rd=5, retire_count=1.
- LHU from addr 0x2 with read_data 0xBEEF_0001 → wb_data=0x0000_BEEF. LH from the same address → wb_data=0xFFFF_BEEF.
- LW from addr 0x6 → wb_misaligned=1, wb_we=0, wb_valid=1, retire_count unchanged. LH from addr 0x1 gives the same result.
- ALU op with rd=0, alu_result 0x1234 → wb_we=0, wb_data=0x1234. JAL with wb_sel=10, pc_plus4 0x100, rd=1 → wb_data=0x100, wb_we=1.
- Hold a captured value, then assert stall for 3 cycles with changing inputs → outputs frozen. Assert stall and flush together → bubble (wb_valid=0, wb_we=0) and counter unchanged.
- Force retire_count to all-ones (or preload via hierarchical force), retire one instruction → retire_count=0. Assert rst_n low mid-stream, asynchronous to clk → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load formatting, writeback select and retire counter
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall, flush    hold contents / insert bubble (flush wins)
//   m_valid         memory stage holds a valid instruction
//   m_rd            destination register
//   m_reg_write     instruction writes rd
//   m_wb_sel        writeback source: 00 ALU, 01 load, 10 pc+4, 11 ALU
//   m_funct3        load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others LW)
//   m_alu_result    ALU result / memory address
//   m_read_data     word read from data memory
//   m_pc_plus4      return address for JAL/JALR
//   wb_valid        writeback holds a valid instruction
//   wb_rd           destination register
//   wb_we           register-file write enable
//   wb_data         data to write (also the forwarding value)
//   wb_misaligned   load-address-misaligned flag for the held instruction
//   retire_count    retired-instruction count
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [4:0]       m_rd,
    input  logic             m_reg_write,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_funct3,
    input  logic [XLEN-1:0]  m_alu_result,
    input  logic [XLEN-1:0]  m_read_data,
    input  logic [XLEN-1:0]  m_pc_plus4,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_we,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_misaligned,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    logic [1:0]      off;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic            is_byte;
    logic            is_half;
    logic            is_word;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] data_nxt;
    logic            mis_nxt;
    logic            we_nxt;
    logic            retire_nxt;

    always_comb begin
        off      = m_alu_result[1:0];
        byte_val = m_read_data[{off, 3'b000} +: 8];
        half_val = off[1] ? m_read_data[31:16] : m_read_data[15:0];

        // Unused funct3 encodings fall through to a full-word load.
        is_byte = (m_funct3 == 3'b000) || (m_funct3 == 3'b100);
        is_half = (m_funct3 == 3'b001) || (m_funct3 == 3'b101);
        is_word = !is_byte && !is_half;

        // funct3[2] distinguishes the unsigned variants of byte/half loads.
        load_data = m_read_data;
        if (is_byte) begin
            load_data = {{(XLEN-8){byte_val[7] & ~m_funct3[2]}}, byte_val};
        end else if (is_half) begin
            load_data = {{(XLEN-16){half_val[15] & ~m_funct3[2]}}, half_val};
        end

        case (m_wb_sel)
            WB_SEL_LOAD: data_nxt = load_data;
            WB_SEL_PC4:  data_nxt = m_pc_plus4;
            default:     data_nxt = m_alu_result;
        endcase

        mis_nxt    = m_valid && (m_wb_sel == WB_SEL_LOAD)
                     && ((is_half && off[0]) || (is_word && (off != 2'b00)));
        we_nxt     = m_valid && m_reg_write && (m_rd != 5'd0) && !mis_nxt;
        retire_nxt = m_valid && !mis_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_we         <= 1'b0;
            wb_data       <= '0;
            wb_misaligned <= 1'b0;
            retire_count  <= '0;
        end else if (flush) begin
            // Bubble: kill the control bits, leave rd/data as they were.
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_misaligned <= 1'b0;
        end else if (!stall) begin
            wb_valid      <= m_valid;
            wb_rd         <= m_rd;
            wb_we         <= we_nxt;
            wb_data       <= data_nxt;
            wb_misaligned <= mis_nxt;
            if (retire_nxt) begin
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, m_valid, m_reg_write;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_result, m_read_data, m_pc_plus4;

    logic        wb_valid, wb_we, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [63:0] retire_count;

    logic        s_valid, s_we, s_mis;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [2:0]  s_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_rd(m_rd), .m_reg_write(m_reg_write),
        .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .wb_misaligned(wb_misaligned), .retire_count(retire_count)
    );

    // Narrow-counter copy so counter wrap is reachable in a short run.
    mem_wb_stage #(.XLEN(32), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_rd(m_rd), .m_reg_write(m_reg_write),
        .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
        .wb_valid(s_valid), .wb_rd(s_rd), .wb_we(s_we), .wb_data(s_data),
        .wb_misaligned(s_mis), .retire_count(s_cnt)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        e_valid;
        logic        e_we;
        logic        e_mis;
        logic        e_chkd;
        logic [31:0] e_data;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    // Reference model state
    logic        r_valid, r_we, r_mis, r_known;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic [63:0] r_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic ev, input logic ewe,
                               input logic emis, input logic [4:0] erd,
                               input logic [31:0] edata, input logic chkd,
                               input logic [63:0] ecnt);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(ev));
        chk({tag, ".wb_we"}, 64'(wb_we), 64'(ewe));
        chk({tag, ".wb_misaligned"}, 64'(wb_misaligned), 64'(emis));
        chk({tag, ".retire_count"}, retire_count, ecnt);
        chk({tag, ".small_count"}, 64'(s_cnt), 64'(ecnt[2:0]));
        if (chkd) begin
            chk({tag, ".wb_rd"}, 64'(wb_rd), 64'(erd));
            chk({tag, ".wb_data"}, 64'(wb_data), 64'(edata));
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        m_valid = v; m_rd = rd; m_reg_write = rw; m_wb_sel = sel;
        m_funct3 = f3; m_alu_result = alu; m_read_data = rdata; m_pc_plus4 = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Higher-level view: loads are a size in bytes and a signedness.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
        int unsigned size, b;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if (size == 1) begin
            b = (word >> (8 * (addr % 4))) & 32'hFF;
            if (f3 == 3'd0 && b >= 128) b = b + 32'hFFFF_FF00;
            return b;
        end else if (size == 2) begin
            b = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && b >= 32768) b = b + 32'hFFFF_0000;
            return b;
        end
        return word;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return (addr % size) != 0;
    endfunction

    task automatic model_step();
        logic mis;
        if (flush) begin
            r_valid = 1'b0; r_we = 1'b0; r_mis = 1'b0;
        end else if (!stall) begin
            mis     = m_valid && (m_wb_sel == 2'd1) && model_mis(m_funct3, m_alu_result);
            r_valid = m_valid;
            r_mis   = mis;
            r_rd    = m_rd;
            r_we    = m_valid && m_reg_write && (m_rd != 0) && !mis;
            r_data  = (m_wb_sel == 2'd1) ? model_load(m_funct3, m_alu_result, m_read_data) :
                      (m_wb_sel == 2'd2) ? m_pc_plus4 : m_alu_result;
            r_known = m_valid && !mis;
            if (m_valid && !mis) r_cnt = r_cnt + 1;
        end
    endtask

    initial begin
        logic [63:0] cnt;

        vecs[0] = '{1'b1, 5'd5, 1'b1, 2'b01, 3'b000, 32'h3, 32'h80FF_1234, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 64'd1};
        vecs[1] = '{1'b1, 5'd6, 1'b1, 2'b01, 3'b101, 32'h2, 32'hBEEF_0001, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_BEEF, 64'd2};
        vecs[2] = '{1'b1, 5'd7, 1'b1, 2'b01, 3'b001, 32'h2, 32'hBEEF_0001, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_BEEF, 64'd3};
        vecs[3] = '{1'b1, 5'd8, 1'b1, 2'b01, 3'b010, 32'h6, 32'h1111_2222, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 64'd3};
        vecs[4] = '{1'b1, 5'd9, 1'b1, 2'b01, 3'b001, 32'h1, 32'h1111_2222, 32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 64'd3};
        vecs[5] = '{1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 64'd4};
        vecs[6] = '{1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h55, 32'h0, 32'h100,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 64'd5};
        vecs[7] = '{1'b1, 5'd9, 1'b1, 2'b11, 3'b000, 32'hCAFE, 32'h0, 32'h200,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE, 64'd6};
        vecs[8] = '{1'b1, 5'd10, 1'b1, 2'b01, 3'b100, 32'h1, 32'h0000_8000, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 64'd7};
        vecs[9] = '{1'b0, 5'd11, 1'b1, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'd7};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0);
        tick();
        tick();
        check_state("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].rw, vecs[i].sel, vecs[i].f3,
                  vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_we,
                        vecs[i].e_mis, vecs[i].rd, vecs[i].e_data, vecs[i].e_chkd,
                        vecs[i].e_cnt);
        end
        cnt = 64'd7;

        // Capture, then stall with changing inputs: everything frozen.
        drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0);
        tick();
        cnt = cnt + 1;
        check_state("stall_cap", 1'b1, 1'b1, 1'b0, 5'd3, 32'h55, 1'b1, cnt);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            drive(1'b1, 5'($urandom_range(1, 31)), 1'b1, 2'b10, 3'b000,
                  $urandom, $urandom, $urandom);
            tick();
            check_state($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 5'd3, 32'h55, 1'b1, cnt);
        end
        flush = 1'b1;
        tick();
        check_state("stall_flush", 1'b0, 1'b0, 1'b0, 5'd3, 32'h55, 1'b1, cnt);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between clock edges.
        drive(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0);
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Eight retirements: the 3-bit counter wraps to 0.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd1, 1'b1, 2'b00, 3'b000, 32'(i), 32'h0, 32'h0);
            tick();
        end
        check_state("wrap", 1'b1, 1'b1, 1'b0, 5'd1, 32'd7, 1'b1, 64'd8);

        // Randomized run against the reference model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        r_valid = 1'b0; r_we = 1'b0; r_mis = 1'b0; r_known = 1'b1;
        r_rd = 5'd0; r_data = 32'h0; r_cnt = 64'd0;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  1'($urandom), 2'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom);
            tick();
            model_step();
            check_state($sformatf("rand%0d", i), r_valid, r_we, r_mis, r_rd, r_data,
                        r_known, r_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
